// File: rtl/rms_meter.sv
// rms_meter: streaming RMS level detector.
// Squares each accepted sample into a window accumulator. When a window of
// 2^LOG2_WIN samples closes, the mean square is taken with an exact shift.
// A bit-serial engine then produces floor(sqrt(mean square)) over DATA_W
// cycles. Accumulation of the next window continues while the root runs.
module rms_meter #(
  parameter int DATA_W   = 16,
  parameter int LOG2_WIN = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     x_in,
  input  logic                  x_valid,
  input  logic                  clear,
  output logic [2*DATA_W-1:0]   ms_out,
  output logic [DATA_W-1:0]     rms_out,
  output logic                  rms_valid,
  output logic                  busy
);

  localparam int ACC_W = 2*DATA_W + LOG2_WIN;
  localparam int SQ_W  = 2*DATA_W;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SQRT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;

  logic [ACC_W-1:0]   acc_r;
  logic [LOG2_WIN-1:0] cnt_r;
  logic [SQ_W-1:0]    ms_reg_r;
  logic [DATA_W-1:0]  root_r;
  logic [SQ_W-1:0]    root_sq_r;
  logic [BIT_W-1:0]   bit_r;

  logic [SQ_W-1:0]    ms_out_r;
  logic [DATA_W-1:0]  rms_out_r;
  logic               rms_valid_r;
  logic               busy_r;

  logic signed [SQ_W-1:0] x_ext_s;
  logic signed [SQ_W-1:0] prod_s;
  logic [ACC_W-1:0]   sum_s;
  logic               close_s;
  logic [DATA_W-1:0]  guess_s;
  logic [SQ_W-1:0]    guess_sq_s;
  logic [SQ_W-1:0]    root_ext_s;
  logic [SQ_W-1:0]    bit_sq_s;

  // Sample square and window sum. The true square never exceeds
  // 2^(2*DATA_W-2), so the signed product read as unsigned is exact.
  assign x_ext_s = {{DATA_W{x_in[DATA_W-1]}}, x_in};
  assign prod_s  = x_ext_s * x_ext_s;
  assign sum_s   = acc_r + {{LOG2_WIN{1'b0}}, prod_s};
  // A clear on the closing edge wins: the window simply restarts.
  assign close_s = x_valid && !clear && (&cnt_r);

  // Trial root for the current bit and its square built incrementally:
  // (r + 2^b)^2 = r^2 + 2^(2b) + r*2^(b+1)
  assign guess_s    = root_r | ({{(DATA_W-1){1'b0}}, 1'b1} << bit_r);
  assign root_ext_s = {{DATA_W{1'b0}}, root_r};
  assign bit_sq_s   = {{(SQ_W-1){1'b0}}, 1'b1} << {bit_r, 1'b0};
  assign guess_sq_s = root_sq_r + bit_sq_s
                    + (root_ext_s << ({1'b0, bit_r} + {{BIT_W{1'b0}}, 1'b1}));

  // Window accumulator and accepted-sample counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= {ACC_W{1'b0}};
      cnt_r <= {LOG2_WIN{1'b0}};
    end else if (clear) begin
      acc_r <= {ACC_W{1'b0}};
      cnt_r <= {LOG2_WIN{1'b0}};
    end else if (close_s) begin
      acc_r <= {ACC_W{1'b0}};
      cnt_r <= {LOG2_WIN{1'b0}};
    end else if (x_valid) begin
      acc_r <= sum_s;
      cnt_r <= cnt_r + {{(LOG2_WIN-1){1'b0}}, 1'b1};
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end

  // Root engine state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Root engine next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (close_s) state_next_s = ST_SQRT;
        else         state_next_s = ST_IDLE;
      end
      ST_SQRT: begin
        if (bit_r == {BIT_W{1'b0}}) state_next_s = ST_DONE;
        else                        state_next_s = ST_SQRT;
      end
      ST_DONE: begin
        if (close_s) state_next_s = ST_SQRT;
        else         state_next_s = ST_IDLE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Mean-square capture and bit-serial root datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      ms_reg_r  <= {SQ_W{1'b0}};
      root_r    <= {DATA_W{1'b0}};
      root_sq_r <= {SQ_W{1'b0}};
      bit_r     <= {BIT_W{1'b0}};
    end else if (close_s) begin
      ms_reg_r  <= sum_s[ACC_W-1:LOG2_WIN];
      root_r    <= {DATA_W{1'b0}};
      root_sq_r <= {SQ_W{1'b0}};
      bit_r     <= BIT_W'(DATA_W-1);
    end else if (state_r == ST_SQRT) begin
      if (guess_sq_s <= ms_reg_r) begin
        root_r    <= guess_s;
        root_sq_r <= guess_sq_s;
      end else begin
        root_r    <= root_r;
        root_sq_r <= root_sq_r;
      end
      bit_r <= bit_r - {{(BIT_W-1){1'b0}}, 1'b1};
    end else begin
      ms_reg_r  <= ms_reg_r;
      root_r    <= root_r;
      root_sq_r <= root_sq_r;
      bit_r     <= bit_r;
    end
  end

  // Registered results, one-cycle strobe and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ms_out_r    <= {SQ_W{1'b0}};
      rms_out_r   <= {DATA_W{1'b0}};
      rms_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      rms_valid_r <= (state_r == ST_DONE);
      busy_r      <= (state_next_s == ST_SQRT);
      if (state_r == ST_DONE) begin
        ms_out_r  <= ms_reg_r;
        rms_out_r <= root_r;
      end else begin
        ms_out_r  <= ms_out_r;
        rms_out_r <= rms_out_r;
      end
    end
  end

  assign ms_out    = ms_out_r;
  assign rms_out   = rms_out_r;
  assign rms_valid = rms_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_rms_meter.sv
// tb_rms_meter: directed test-plan scenarios plus random traffic, checked
// every cycle against a window/queue reference model of rms_meter.
module tb_rms_meter;

  localparam int DW  = 16;
  localparam int LW  = 5;
  localparam int WIN = 1 << LW;

  logic          clk;
  logic          rst;
  logic [DW-1:0] x_in;
  logic          x_valid;
  logic          clear;
  logic [2*DW-1:0] ms_out;
  logic [DW-1:0] rms_out;
  logic          rms_valid;
  logic          busy;

  int tests_run;
  int tests_failed;

  rms_meter #(.DATA_W(DW), .LOG2_WIN(LW)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .clear(clear),
    .ms_out(ms_out), .rms_out(rms_out), .rms_valid(rms_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests_run++;
    if (obs !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  // Floor square root by binary search on plain integers.
  function automatic longint isqrt(input longint v);
    longint lo, hi, mid;
    lo = 0; hi = 65536;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // Reference model state
  longint win_q[$];          // squares of accepted samples in current window
  longint due_q[$];          // cycle at which each pending result appears
  longint ms_q[$];
  longint rms_q[$];
  longint cyc;
  int     busy_left;
  logic   exp_valid;
  longint exp_ms, exp_rms;
  logic   model_live;

  // Reference model: evaluates the spec rules on each rising edge.
  always @(posedge clk) begin
    longint s, xs;
    cyc++;
    exp_valid = 1'b0;
    if (rst) begin
      win_q.delete(); due_q.delete(); ms_q.delete(); rms_q.delete();
      busy_left = 0; exp_ms = 0; exp_rms = 0;
    end else begin
      if (busy_left > 0) busy_left--;
      if (clear) begin
        win_q.delete();
      end else if (x_valid) begin
        xs = longint'($signed(x_in));
        win_q.push_back(xs * xs);
        if (win_q.size() == WIN) begin
          s = 0;
          foreach (win_q[i]) s += win_q[i];
          win_q.delete();
          ms_q.push_back(s / WIN);
          rms_q.push_back(isqrt(s / WIN));
          due_q.push_back(cyc + DW + 1);
          busy_left = DW;
        end
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        exp_ms = ms_q.pop_front();
        exp_rms = rms_q.pop_front();
        exp_valid = 1'b1;
      end
    end
    model_live = 1'b1;
  end

  // Per-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("rms_valid", {63'd0, rms_valid}, {63'd0, exp_valid});
      check("busy", {63'd0, busy}, {63'd0, (busy_left > 0)});
      check("ms_out", {32'd0, ms_out}, exp_ms);
      check("rms_out", {48'd0, rms_out}, exp_rms);
    end
  end

  task automatic drive(input logic [DW-1:0] x, input logic v, input logic c);
    x_in = x; x_valid = v; clear = c;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    cyc = 0; busy_left = 0; exp_valid = 1'b0; exp_ms = 0; exp_rms = 0;
    model_live = 1'b0;
    rst = 1'b1; x_in = 16'h0000; x_valid = 1'b0; clear = 1'b0;
    idle(3);
    check("reset_ms", {32'd0, ms_out}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    idle(2);

    // 1: constant 0x1000
    for (int i = 0; i < WIN; i++) drive(16'h1000, 1'b1, 1'b0);
    idle(20);
    check("t1_ms", {32'd0, ms_out}, 64'd16777216);
    check("t1_rms", {48'd0, rms_out}, 64'd4096);

    // 2: most-negative input
    for (int i = 0; i < WIN; i++) drive(16'h8000, 1'b1, 1'b0);
    idle(20);
    check("t2_ms", {32'd0, ms_out}, 64'd1073741824);
    check("t2_rms", {48'd0, rms_out}, 64'd32768);

    // 3: alternating +/-100, three back-to-back windows
    for (int i = 0; i < 3*WIN; i++)
      drive((i % 2 == 0) ? 16'd100 : 16'hFF9C, 1'b1, 1'b0);
    idle(20);
    check("t3_rms", {48'd0, rms_out}, 64'd100);

    // 4: 16 ones then 16 twos with gaps
    for (int i = 0; i < WIN; i++) begin
      drive((i < WIN/2) ? 16'd1 : 16'd2, 1'b1, 1'b0);
      drive(16'($urandom), 1'b0, 1'b0);
    end
    idle(20);
    check("t4_ms", {32'd0, ms_out}, 64'd2);
    check("t4_rms", {48'd0, rms_out}, 64'd1);

    // 5: reset during the root
    for (int i = 0; i < WIN; i++) drive(16'h1000, 1'b1, 1'b0);
    idle(5);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(20);
    check("t5_ms_after_rst", {32'd0, ms_out}, 64'd0);
    check("t5_rms_after_rst", {48'd0, rms_out}, 64'd0);
    for (int i = 0; i < WIN; i++) drive(16'h0100, 1'b1, 1'b0);
    idle(20);
    check("t5_rms", {48'd0, rms_out}, 64'd256);

    // 6: clear discards a partial window; clear on closing sample wins
    for (int i = 0; i < 20; i++) drive(16'h7FFF, 1'b1, 1'b0);
    drive(16'h7FFF, 1'b1, 1'b1);
    for (int i = 0; i < WIN; i++) drive(16'd3, 1'b1, 1'b0);
    idle(20);
    check("t6_ms", {32'd0, ms_out}, 64'd9);
    check("t6_rms", {48'd0, rms_out}, 64'd3);
    for (int i = 0; i < WIN-1; i++) drive(16'd5, 1'b1, 1'b0);
    drive(16'd5, 1'b1, 1'b1);
    idle(20);
    check("t6_no_close", {48'd0, rms_out}, 64'd3);

    // Random traffic: mixed amplitudes, gaps and occasional clears
    for (int i = 0; i < 1500; i++) begin
      logic [DW-1:0] xr;
      xr = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 300)) - 16'd150
                                       : 16'($urandom);
      drive(xr, ($urandom_range(0, 3) != 0), ($urandom_range(0, 255) == 0));
    end
    idle(25);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
